jstk_spi_responder: RTL and testbench
=====================================

// Module: jstk_spi_responder
// PURPOSE
// - SPI slave (mode 0, MSB first) that answers the PmodJSTK 5-byte frame: returns X/Y position and buttons on miso, accepts the LED command byte on mosi.
// - Used as a joystick stand-in for board-to-board links and for closed-loop simulation against the PmodJSTK master interface.
// - Sits between the external SPI pins (ss/sclk/mosi/miso) and a position source (x_pos, y_pos, buttons).
// PARAMETERS
// - SYNC_STAGES     2          flops in each input synchronizer (>=2)
// - FRAME_BYTES     5          bytes in one legal frame
// - LED_CMD_PREFIX  6'b100000  cmd[7:2] value that marks an LED-set command
// PORTS
// - clk         in   1   system clock; must be >= 8x the sclk frequency
// - rst         in   1   reset, synchronous, active-high
// - ss          in   1   slave select, active-low, asynchronous to clk
// - sclk        in   1   SPI clock, idle low, asynchronous to clk
// - mosi        in   1   master-out data, sampled on sclk rising edge
// - miso        out  1   slave-out data, updated on sclk falling edge
// - x_pos       in   10  X position, 0..1023
// - y_pos       in   10  Y position, 0..1023
// - buttons     in   3   {btn2, btn1, jstk_btn}
// - led_cmd     out  2   LED bits from the last accepted command
// - frame_done  out  1   1-cycle pulse: legal 40-bit frame completed
// - frame_err   out  1   1-cycle pulse: frame ended with bit count != 40
// BEHAVIOUR
// Reset
// - After rst: miso=0, led_cmd=0, frame_done=0, frame_err=0, state IDLE, all counters=0.
// Input conditioning
// - ss, sclk and mosi each pass through SYNC_STAGES flops, then an edge detector.
// - All decisions below use the synchronized signals and their edges.
// State machine
// - IDLE -> ACTIVE on a synchronized ss falling edge.
//   - Snapshot the 40-bit tx word {x[7:0], 6'b0, x[9:8], y[7:0], 6'b0, y[9:8], 5'b0, buttons}.
//   - Drive tx[39] on miso in the same cycle.
//   - Clear bit_cnt (0..7) and byte_cnt (0..FRAME_BYTES).
// - ACTIVE, sclk rising edge: shift mosi into rx_byte; bit_cnt++.
//   - When bit_cnt wraps 7->0: byte_cnt++.
//   - When byte_cnt goes 0->1: latch rx_byte as cmd.
//   - byte_cnt saturates at FRAME_BYTES+1.
// - ACTIVE, sclk falling edge: shift tx left with 0 fill; miso = new tx[39].
//   - Bytes beyond FRAME_BYTES therefore read 0x00.
// - ACTIVE -> IDLE on a synchronized ss rising edge.
//   - Legal frame (byte_cnt==FRAME_BYTES and bit_cnt==0): pulse frame_done next cycle.
//     If cmd[7:2]==LED_CMD_PREFIX, also set led_cmd=cmd[1:0] in that cycle.
//   - Any other bit count: pulse frame_err; led_cmd unchanged.
//   - miso=0 while IDLE.
// Ordering and boundaries
// - ss rising edge in the same cycle as an sclk edge: the ss edge wins and the sclk edge is ignored.
// - x_pos, y_pos and buttons changes during ACTIVE have no effect until the next frame.
// - rst mid-frame aborts the frame: no done/err pulse.
//   - If ss is still low after rst, the responder stays IDLE until ss goes high and then low again.
// - Latency: miso is valid SYNC_STAGES+1 clk after the pin-level ss fall, and SYNC_STAGES+1 clk after each pin-level sclk fall.
// STRUCTURE
// - Shared package jstk_pkg:
//   - JSTK_FRAME_BYTES=5
//   - JSTK_LED_PREFIX=6'b100000
//   - JSTK_POS_W=10
//   - state encoding {IDLE, ACTIVE}
//   - function pack_jstk_frame(x, y, buttons) -> [39:0]
// - One sub-module, spi_sync_edge: SYNC_STAGES synchronizer with rise/fall pulse outputs.
//   - Instantiated for ss, sclk and mosi; the mosi instance uses only its level output.
// TESTING
// - Legal frame, LED command:
//   - Stimulus: x=512, y=300, buttons=3'b101; master sends 0x83,0,0,0,0.
//   - Required: miso bytes 0x00,0x02,0x2C,0x01,0x05; frame_done pulses once; led_cmd=2'b11.
// - Non-LED command:
//   - Stimulus: cmd 0x40.
//   - Required: frame_done pulses; led_cmd keeps 2'b11.
// - Short frame:
//   - Stimulus: 3 bytes, then ss high.
//   - Required: frame_err pulses; no frame_done; led_cmd unchanged.
// - Long frame:
//   - Stimulus: 6 bytes.
//   - Required: 6th miso byte is 0x00; frame_err pulses.
// - Snapshot hold:
//   - Stimulus: change x from 512 to 1023 after byte 1.
//   - Required: bytes 0x00,0x02 are unchanged; the next frame returns 0xFF,0x03.
// - Reset mid-frame:
//   - Stimulus: rst during byte 2 with ss held low.
//   - Required: miso=0; no pulse; after an ss high->low cycle, the next frame is correct.

Source files
------------

// File: rtl/jstk_pkg.sv
// Shared constants, state encoding and frame packing for the PmodJSTK SPI responder.
package jstk_pkg;

  localparam int          JSTK_FRAME_BYTES = 5;
  localparam logic [5:0]  JSTK_LED_PREFIX  = 6'b100000;
  localparam int          JSTK_POS_W       = 10;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } jstk_state_e;

  // Byte order on the wire: X low, X high, Y low, Y high, buttons.
  function automatic logic [39:0] pack_jstk_frame(
    input logic [JSTK_POS_W-1:0] x,
    input logic [JSTK_POS_W-1:0] y,
    input logic [2:0]            buttons
  );
    return {x[7:0], 6'b0, x[9:8], y[7:0], 6'b0, y[9:8], 5'b0, buttons};
  endfunction

endpackage

// File: rtl/jstk_spi_responder_if.sv
// SPI pin bundle between a PmodJSTK-style master and the responder.
interface jstk_spi_responder_if;
  logic ss;
  logic sclk;
  logic mosi;
  logic miso;

  modport master (output ss, output sclk, output mosi, input miso);
  modport slave  (input ss, input sclk, input mosi, output miso);
endinterface

// File: rtl/jstk_spi_responder_spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with registered-level edge pulses.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_d;

  // Reset to 0 so a pin already low at reset release never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      level_d <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
      level_d <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~level_d;
  assign fall  = ~level & level_d;

endmodule

// File: rtl/jstk_spi_responder.sv
// SPI mode-0 slave that emulates a PmodJSTK: serves X/Y/buttons, accepts the LED command.
//
// state  | meaning
// IDLE   | ss high (or frame aborted by reset); miso held 0
// ACTIVE | frame in progress; shifting rx on sclk rise, tx on sclk fall
module jstk_spi_responder
  import jstk_pkg::*;
#(
  parameter int         SYNC_STAGES    = 2,
  parameter int         FRAME_BYTES    = JSTK_FRAME_BYTES,
  parameter logic [5:0] LED_CMD_PREFIX = JSTK_LED_PREFIX
) (
  input  logic                    clk,
  input  logic                    rst,
  jstk_spi_responder_if.slave     spi,
  input  logic [JSTK_POS_W-1:0]   x_pos,
  input  logic [JSTK_POS_W-1:0]   y_pos,
  input  logic [2:0]              buttons,
  output logic [1:0]              led_cmd,
  output logic                    frame_done,
  output logic                    frame_err
);

  localparam int BC_W = $clog2(FRAME_BYTES + 2);
  localparam logic [BC_W-1:0] BYTE_LAST = BC_W'(FRAME_BYTES);
  localparam logic [BC_W-1:0] BYTE_SAT  = BC_W'(FRAME_BYTES + 1);

  logic ss_level, ss_rise, ss_fall;
  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic mosi_level, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
    .clk   (clk),
    .rst   (rst),
    .din   (spi.ss),
    .level (ss_level),
    .rise  (ss_rise),
    .fall  (ss_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk   (clk),
    .rst   (rst),
    .din   (spi.sclk),
    .level (sclk_level_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk   (clk),
    .rst   (rst),
    .din   (spi.mosi),
    .level (mosi_level),
    .rise  (mosi_rise_unused),
    .fall  (mosi_fall_unused)
  );

  jstk_state_e     state;
  logic [39:0]     tx_word;
  logic [7:0]      rx_byte;
  logic [7:0]      cmd;
  logic [2:0]      bit_cnt;
  logic [BC_W-1:0] byte_cnt;
  logic            miso_q;
  logic [7:0]      rx_next;
  logic [39:0]     frame_word;

  assign rx_next    = {rx_byte[6:0], mosi_level};
  assign frame_word = pack_jstk_frame(x_pos, y_pos, buttons);
  assign spi.miso   = miso_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx_word    <= '0;
      rx_byte    <= '0;
      cmd        <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      miso_q     <= 1'b0;
      led_cmd    <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          miso_q <= 1'b0;
          if (ss_fall) begin
            state    <= ACTIVE;
            tx_word  <= frame_word;
            miso_q   <= frame_word[39];
            bit_cnt  <= '0;
            byte_cnt <= '0;
            rx_byte  <= '0;
          end
        end
        ACTIVE: begin
          // ss release takes priority over any sclk edge seen in the same cycle.
          if (ss_rise) begin
            state  <= IDLE;
            miso_q <= 1'b0;
            if (byte_cnt == BYTE_LAST && bit_cnt == 3'd0) begin
              frame_done <= 1'b1;
              if (cmd[7:2] == LED_CMD_PREFIX) led_cmd <= cmd[1:0];
            end else begin
              frame_err <= 1'b1;
            end
          end else if (sclk_rise) begin
            rx_byte <= rx_next;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (byte_cnt != BYTE_SAT) byte_cnt <= byte_cnt + 1'b1;
              if (byte_cnt == '0) cmd <= rx_next;
            end
          end else if (sclk_fall) begin
            tx_word <= {tx_word[38:0], 1'b0};
            miso_q  <= tx_word[38];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jstk_spi_responder.sv
// Directed bench: table of full frames plus hand sequences for snapshot hold and mid-frame reset.
module tb_jstk_spi_responder;

  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] x_pos = '0;
  logic [9:0] y_pos = '0;
  logic [2:0] buttons = '0;
  logic [1:0] led_cmd;
  logic       frame_done;
  logic       frame_err;

  jstk_spi_responder_if jif ();

  jstk_spi_responder dut (
    .clk        (clk),
    .rst        (rst),
    .spi        (jif.slave),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .buttons    (buttons),
    .led_cmd    (led_cmd),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int done_cnt = 0;
  int err_cnt  = 0;
  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (frame_err)  err_cnt++;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", nm, act, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_start();
    jif.ss = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic spi_bit(input logic m, output logic s);
    jif.mosi = m;
    wait_clk(HALF);
    s = jif.miso;
    jif.sclk = 1'b1;
    wait_clk(HALF);
    jif.sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] m, output logic [7:0] s);
    for (int b = 7; b >= 0; b--) spi_bit(m[b], s[b]);
  endtask

  task automatic spi_end();
    wait_clk(HALF);
    jif.ss = 1'b1;
    wait_clk(12);
  endtask

  typedef struct {
    logic [9:0]       x;
    logic [9:0]       y;
    logic [2:0]       btn;
    logic [7:0]       cmd;
    int               nbytes;
    logic [0:5][7:0]  em;
    int               exp_done;
    int               exp_err;
    logic [1:0]       exp_led;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [7:0] got;
    logic       bit_got;
    logic       miso_seen;
    int d0, e0;

    vecs[0] = '{x:10'd512,  y:10'd300,  btn:3'b101, cmd:8'h83, nbytes:5, em:48'h00022C010500, exp_done:1, exp_err:0, exp_led:2'b11};
    vecs[1] = '{x:10'd512,  y:10'd300,  btn:3'b101, cmd:8'h40, nbytes:5, em:48'h00022C010500, exp_done:1, exp_err:0, exp_led:2'b11};
    vecs[2] = '{x:10'd512,  y:10'd300,  btn:3'b101, cmd:8'h81, nbytes:3, em:48'h00022C000000, exp_done:0, exp_err:1, exp_led:2'b11};
    vecs[3] = '{x:10'd512,  y:10'd300,  btn:3'b101, cmd:8'h80, nbytes:6, em:48'h00022C010500, exp_done:0, exp_err:1, exp_led:2'b11};
    vecs[4] = '{x:10'd1023, y:10'd0,    btn:3'b000, cmd:8'h80, nbytes:5, em:48'hFF0300000000, exp_done:1, exp_err:0, exp_led:2'b00};
    vecs[5] = '{x:10'd5,    y:10'd1023, btn:3'b010, cmd:8'h81, nbytes:5, em:48'h0500FF030200, exp_done:1, exp_err:0, exp_led:2'b01};

    jif.ss = 1'b1;
    jif.sclk = 1'b0;
    jif.mosi = 1'b0;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(6);

    chk("reset_miso", 32'(jif.miso), 32'd0);
    chk("reset_led", 32'(led_cmd), 32'd0);
    chk("reset_pulses", 32'(done_cnt + err_cnt), 32'd0);

    for (int i = 0; i < 6; i++) begin
      x_pos = vecs[i].x;
      y_pos = vecs[i].y;
      buttons = vecs[i].btn;
      d0 = done_cnt;
      e0 = err_cnt;
      spi_start();
      for (int k = 0; k < vecs[i].nbytes; k++) begin
        spi_byte((k == 0) ? vecs[i].cmd : 8'h00, got);
        chk($sformatf("v%0d_miso_b%0d", i, k), 32'(got), 32'(vecs[i].em[k]));
      end
      spi_end();
      chk($sformatf("v%0d_done", i), 32'(done_cnt - d0), 32'(vecs[i].exp_done));
      chk($sformatf("v%0d_err", i), 32'(err_cnt - e0), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_led", i), 32'(led_cmd), 32'(vecs[i].exp_led));
      chk($sformatf("v%0d_idle_miso", i), 32'(jif.miso), 32'd0);
    end

    // Snapshot hold: x changes after byte 0 must not disturb the frame in flight.
    x_pos = 10'd512;
    y_pos = 10'd300;
    buttons = 3'b101;
    d0 = done_cnt;
    spi_start();
    spi_byte(8'h40, got);
    chk("snap_b0", 32'(got), 32'h00);
    x_pos = 10'd1023;
    spi_byte(8'h00, got);
    chk("snap_b1", 32'(got), 32'h02);
    spi_byte(8'h00, got);
    chk("snap_b2", 32'(got), 32'h2C);
    spi_byte(8'h00, got);
    chk("snap_b3", 32'(got), 32'h01);
    spi_byte(8'h00, got);
    chk("snap_b4", 32'(got), 32'h05);
    spi_end();
    chk("snap_done", 32'(done_cnt - d0), 32'd1);
    spi_start();
    spi_byte(8'h00, got);
    chk("snap_next_b0", 32'(got), 32'hFF);
    spi_byte(8'h00, got);
    chk("snap_next_b1", 32'(got), 32'h03);
    for (int k = 2; k < 5; k++) spi_byte(8'h00, got);
    spi_end();
    chk("snap_led_kept", 32'(led_cmd), 32'b01);

    // Reset in the middle of byte 1 while ss stays low.
    x_pos = 10'd1023;
    y_pos = 10'd1023;
    buttons = 3'b111;
    d0 = done_cnt;
    e0 = err_cnt;
    spi_start();
    spi_byte(8'h83, got);
    chk("rst_pre_b0", 32'(got), 32'hFF);
    for (int b = 0; b < 4; b++) spi_bit(1'b0, bit_got);
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(2);
    chk("rst_mid_miso", 32'(jif.miso), 32'd0);
    chk("rst_mid_led", 32'(led_cmd), 32'd0);
    miso_seen = 1'b0;
    for (int b = 0; b < 12; b++) begin
      spi_bit(1'b1, bit_got);
      miso_seen = miso_seen | bit_got;
    end
    chk("rst_idle_miso", 32'(miso_seen), 32'd0);
    spi_end();
    chk("rst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("rst_no_err", 32'(err_cnt - e0), 32'd0);

    x_pos = 10'd512;
    y_pos = 10'd300;
    buttons = 3'b101;
    d0 = done_cnt;
    spi_start();
    for (int k = 0; k < 5; k++) begin
      spi_byte((k == 0) ? 8'h83 : 8'h00, got);
      chk($sformatf("rst_after_b%0d", k), 32'(got), 32'(vecs[0].em[k]));
    end
    spi_end();
    chk("rst_after_done", 32'(done_cnt - d0), 32'd1);
    chk("rst_after_led", 32'(led_cmd), 32'b11);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
